// File: rtl/fifo_ctrl_sc_pkg.sv
// fifo_ctrl_sc_pkg: shared types for the single-clock FIFO controller.
// Revision: 1.0
`default_nettype none

package fifo_ctrl_sc_pkg;

  // Accepted-operation code: {push_acc, pop_acc}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_t;

endpackage

`default_nettype wire

// File: rtl/fifo_ctrl_sc.sv
// fifo_ctrl_sc: pointer/count controller for an external RAM, first-word-fall-through.
// Revision: 1.0
`default_nettype none

module fifo_ctrl_sc
  import fifo_ctrl_sc_pkg::*;
#(
  parameter int aw     = 2,
  parameter int dw     = 8,
  parameter int af_lvl = 3,
  parameter int ae_lvl = 1
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [dw-1:0] din,
  input  logic          pop,
  output logic [dw-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [aw:0]   count,
  output logic          ovf,
  output logic          unf,
  input  logic          clr_err,
  output logic          ram_wr,
  output logic [aw-1:0] ram_wa,
  output logic [dw-1:0] ram_di,
  output logic          ram_rd,
  output logic [aw-1:0] ram_ra,
  input  logic [dw-1:0] ram_dq
);

  localparam logic [aw:0] DEPTH = {1'b1, {aw{1'b0}}};

  logic [aw-1:0] wp;
  logic [aw-1:0] rp;
  logic [aw:0]   cnt;
  logic          push_acc;
  logic          pop_acc;
  logic          ovf_set;
  logic          unf_set;
  fifo_op_t      op;

  // Status flags depend on cnt alone, so they track the post-edge occupancy.
  assign full   = (cnt == DEPTH);
  assign empty  = (cnt == '0);
  assign afull  = (32'(cnt) >= 32'(af_lvl));
  assign aempty = (32'(cnt) <= 32'(ae_lvl));
  assign count  = cnt;

  always_comb begin
    pop_acc  = 1'b0;
    push_acc = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (!rst && !flush) begin
      pop_acc  = pop && !empty;
      // A pop while full frees the slot the simultaneous push writes into.
      push_acc = push && (!full || pop_acc);
      ovf_set  = push && full && !pop_acc;
      unf_set  = pop && empty;
    end
    op = fifo_op_t'({push_acc, pop_acc});
  end

  assign ram_wr = push_acc;
  assign ram_wa = wp;
  assign ram_di = din;
  assign ram_rd = pop_acc;
  assign ram_ra = rp;
  assign dout   = ram_dq;

  always_ff @(posedge ck) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_acc) wp <= wp + 1'b1;
      if (pop_acc)  rp <= rp + 1'b1;
      case (op)
        OP_PUSH: cnt <= cnt + 1'b1;
        OP_POP:  cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A fresh error in the clearing cycle takes precedence over clr_err.
  always_ff @(posedge ck) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_set || (ovf && !clr_err);
      unf <= unf_set || (unf && !clr_err);
    end
  end

endmodule

`default_nettype wire

// File: doc/fifo_ctrl_sc.md
FIFO_CTRL_SC -- requirements
Module: fifo_ctrl_sc

Interface
REQ-001 Parameter aw, default 2, RAM address width; depth = 2**aw entries.
REQ-002 Parameter dw, default 8, data width.
REQ-003 Parameter af_lvl, default 3, almost-full threshold; afull asserts when count >= af_lvl.
REQ-004 Parameter ae_lvl, default 1, almost-empty threshold; aempty asserts when count <= ae_lvl.
REQ-005 The block SHALL have one clock and a synchronous active-high reset. Ports, clock and reset first:
- ck, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous pointer clear.
- push, input, 1, write request.
- din, input, dw, write data.
- pop, input, 1, read request.
- dout, output, dw, head-of-queue data (first-word-fall-through).
- full, output, 1, count == 2**aw.
- empty, output, 1, count == 0.
- afull, output, 1, almost full.
- aempty, output, 1, almost empty.
- count, output, aw+1, current occupancy.
- ovf, output, 1, sticky overflow flag.
- unf, output, 1, sticky underflow flag.
- clr_err, input, 1, clears ovf and unf.
- ram_wr, output, 1, RAM write enable.
- ram_wa, output, aw, RAM write address.
- ram_di, output, dw, RAM write data.
- ram_rd, output, 1, RAM read strobe.
- ram_ra, output, aw, RAM read address.
- ram_dq, input, dw, RAM combinational read data.

Function
REQ-006 Internal state SHALL be wp[aw-1:0], rp[aw-1:0] and cnt[aw:0]; all three wrap modulo their width.
REQ-007 A push SHALL be accepted when push && (!full || pop_acc); pop_acc SHALL be pop && !empty.
REQ-008 An accepted push SHALL drive ram_wr=1, ram_wa=wp and ram_di=din combinationally in the same cycle, and SHALL increment wp at the clock edge.
REQ-009 ram_ra SHALL equal rp at all times, and dout SHALL equal ram_dq. ram_rd SHALL equal pop_acc.
REQ-010 An accepted pop SHALL increment rp at the clock edge. Data written in cycle N SHALL appear on dout no earlier than cycle N+1.
REQ-011 cnt SHALL update as follows: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
REQ-012 A simultaneous push and pop while full SHALL accept both. The RAM returns the old head combinationally before the write edge, and cnt stays at 2**aw.
REQ-013 A simultaneous push and pop while empty SHALL accept the push only, reject the pop and set unf.
REQ-014 A push rejected while full SHALL leave the state unchanged and set ovf. A pop while empty SHALL set unf.
REQ-015 full, empty, afull, aempty and count SHALL be registered, or derived combinationally from cnt only; they SHALL reflect the post-edge cnt with no extra latency.
REQ-016 When asserted, flush SHALL set wp=rp=cnt=0 at the next edge. flush SHALL override push and pop in that cycle, and ram_wr SHALL be 0 while flush=1. flush SHALL NOT clear ovf or unf.
REQ-017 clr_err SHALL clear ovf and unf at the next edge. A new error in the same cycle SHALL win and set the flag.

Reset
REQ-018 On rst=1 at a clock edge, the block SHALL set wp=0, rp=0, cnt=0, ovf=0 and unf=0. As a result empty=1, aempty=1, full=0 and afull=0 (given ae_lvl >= 0 and af_lvl >= 1).
REQ-019 While rst=1, ram_wr and ram_rd SHALL be 0. rst SHALL have priority over flush, push, pop and clr_err.
REQ-020 Reset asserted mid-operation SHALL discard all queued entries; RAM contents are don't-care.

Structure
REQ-021 No shared package is required. Parameters are local to the module and the default values match the storage block defaults (aw=2, dw=8).
REQ-022 The block SHALL have no sub-module. The storage RAM is instantiated beside the controller at the parent level and connected through the ram_* ports.

Verification
REQ-023 Reset, then push 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles -> full=1, count=4, afull=1 from the 3rd write; a 5th push sets ovf=1 and leaves count=4.
REQ-024 From full, pop 4 times -> dout sequence A1, A2, A3, A4; empty=1 after the 4th pop; a 5th pop sets unf=1.
REQ-025 Hold full, then push 0xB5 and pop together -> dout shows A1 that cycle, then A2; count stays 4; 0xB5 emerges after A4.
REQ-026 While empty, push 0x5C and pop together -> unf=1, count=1, dout=0x5C the next cycle.
REQ-027 Run 10 push/pop pairs with an offset so wp and rp wrap past 3 -> data order is preserved and count is never out of range.
REQ-028 With count=3, assert flush together with push -> count=0, empty=1, no ram_wr, ovf and unf unchanged; then assert rst mid-stream -> all flags return to their reset values.
